uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one uart_transmitter among NUM_REQ message sources (e.g. per-core nonce reporters).
//  Round-robin grant at message granularity; latches the whole message, frees the requester, then
//  feeds bytes to the transmitter via its tx_ready / new-byte handshake. Sits between hashing cores and UART.
// PARAMETERS
//  NUM_REQ    4  number of requesters, 2..16
//  MSG_BYTES  4  payload bytes per message, 1..8
// PORTS
//  clk          in   1                    single clock; all logic on posedge
//  reset_n      in   1                    synchronous, active-low reset
//  req_valid    in   NUM_REQ              bit i: requester i has a message pending; held until ack
//  req_data     in   NUM_REQ*MSG_BYTES*8  requester i payload at [i*MSG_BYTES*8 +: MSG_BYTES*8]
//  req_ack      out  NUM_REQ              one-cycle pulse: message i latched; requester may drop valid
//  tx_ready     in   1                    from uart_transmitter; already gated low while tx_new_byte=1
//  tx_new_byte  out  1                    to transmitter rx_new_byte; one-cycle registered pulse
//  tx_byte      out  8                    to transmitter rx_byte; valid while tx_new_byte=1
//  busy         out  1                    high in any state other than IDLE
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, req_ack=0, tx_new_byte=0, tx_byte=0, busy=0, rr_last=NUM_REQ-1.
//  - Reset mid-message: message dropped, never re-sent; frame already in transmitter completes (it has
//    no reset); first post-reset byte waits for tx_ready=1.
//  - IDLE: if any req_valid, grant = first set bit scanning rr_last+1, +2, ... mod NUM_REQ; latch
//    req_data slice into msg_buf, idx=0, rr_last=grant, next cycle req_ack[grant]=1, go SEND.
//    No req_valid: stay IDLE. Exactly one ack bit ever high; ack registered (1 cycle after latch).
//  - SEND: when tx_ready=1 and tx_new_byte=0, register tx_new_byte=1, tx_byte=current byte; go WAIT.
//  - WAIT: tx_new_byte back to 0; wait for tx_ready=1 (transmitter shows 0 from the cycle after the
//    pulse until the frame ends). Then: if idx==last byte go IDLE, else idx+=1 and go SEND.
//  - Never two tx_new_byte pulses without tx_ready=0 observed between them; never pulse on tx_ready=0.
//  - Byte order: payload LSB byte first (msg_buf[7:0] first). idx width = clog2(MSG_BYTES+1).
//  - Grant held for the whole message; req_valid changes during SEND/WAIT ignored; requester that
//    keeps valid after ack is re-arbitrated in next IDLE as a new message (its turn is last).
//  - Back-to-back: IDLE->arbitrate costs 1 cycle; no inter-message gap beyond that.
//  - Fairness: with all NUM_REQ valid continuously, grants cycle 0,1,..,NUM_REQ-1,0,...
// CONFIGURATION
//  UART_TX_SCHED_HEADER_EN defined: each message is preceded by header byte {4'hA, grant[3:0]};
//    frame = 1+MSG_BYTES bytes; idx 0 = header. Undefined: frame = MSG_BYTES payload bytes only.
// STRUCTURE
//  uart_tx_sched_pkg: state enum (IDLE, SEND, WAIT), HDR_TAG=4'hA, MAX_REQ=16, MAX_MSG_BYTES=8.
//  Sub-module uart_rr_arbiter: combinational next-grant from req_valid and rr_last (one-hot + index out).
//  Top holds FSM, msg_buf shift/index mux, ack/tx registers.
// TESTING  (bench transmitter: comm_clk_frequency=1_000_000, baud_rate=100_000 -> 10 clk/bit)
//  1 Reset: reset_n=0 5 cycles with req_valid=4'hF -> no ack, tx_new_byte=0, busy=0 throughout.
//  2 Single: req_valid[2]=1, data2=32'h44332211 -> req_ack=4'b0100 once; UART line decodes
//    11,22,33,44 (header A2 first if UART_TX_SCHED_HEADER_EN); busy falls after last stop bit.
//  3 Round-robin: req_valid=4'hF held, re-raised after each ack -> grant order 0,1,2,3,0,1.
//  4 Handshake: check every tx_new_byte pulse has tx_ready=1 the cycle before and one tx_ready=0 between pulses.
//  5 Reset mid-message after 2nd byte pulse -> no further pulses until tx_ready=1; next grant from rr_last=3 (req 0).
//  6 Late request: req_valid[1] rises while req 3 in WAIT -> req 1 served after req 3 frame, ack exactly once.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional header byte per message is enabled by defining UART_TX_SCHED_HEADER_EN.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StWait = 2'd2
    } sched_state_e;

    // Upper nibble of the optional per-message header byte
    localparam logic [3:0] HDR_TAG = 4'hA;

    localparam int unsigned MAX_REQ       = 16;
    localparam int unsigned MAX_MSG_BYTES = 8;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester after i_rr_last.
module uart_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_last,
    output logic                       o_any,
    output logic [NUM_REQ-1:0]         o_grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("uart_rr_arbiter: NUM_REQ out of range");
    end

    logic [IDX_W:0] w_cand;
    logic           w_found;

    assign o_any = |i_req_valid;

    // Scan rr_last+1, rr_last+2, ... (mod NUM_REQ) and take the first set bit
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, i_rr_last} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!w_found && i_req_valid[w_cand[IDX_W-1:0]]) begin
                w_found                         = 1'b1;
                o_grant_idx                     = w_cand[IDX_W-1:0];
                o_grant_oh[w_cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ message sources. A whole message is latched on
// grant (requester freed by a one-cycle ack), then fed byte by byte, LSB byte first, through
// the transmitter's tx_ready / new-byte handshake.
// Define UART_TX_SCHED_HEADER_EN to prefix each message with header byte {4'hA, grant}.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MSG_BYTES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*MSG_BYTES*8-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    input  logic                           tx_ready,
    output logic                           tx_new_byte,
    output logic [7:0]                     tx_byte,
    output logic                           busy
);

    localparam int unsigned GNT_W = $clog2(NUM_REQ);
    localparam int unsigned MSG_W = MSG_BYTES * 8;
`ifdef UART_TX_SCHED_HEADER_EN
    localparam int unsigned FRAME_BYTES = MSG_BYTES + 1;
`else
    localparam int unsigned FRAME_BYTES = MSG_BYTES;
`endif
    localparam int unsigned      IDX_W    = $clog2(MSG_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    if (MSG_BYTES < 1 || MSG_BYTES > MAX_MSG_BYTES) begin : g_bad_msg_bytes
        $error("uart_tx_scheduler: MSG_BYTES out of range");
    end

    sched_state_e       r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic               r_tx_new_byte, w_tx_new_nxt;
    logic [7:0]         r_tx_byte, w_tx_byte_nxt;
    logic [MSG_W-1:0]   r_msg_buf, w_msg_buf_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [GNT_W-1:0]   r_rr_last, w_rr_last_nxt;
    // Set once tx_ready has been seen low after our pulse, so a stale high never re-triggers
    logic               r_low_seen, w_low_seen_nxt;
`ifdef UART_TX_SCHED_HEADER_EN
    logic [3:0]         r_grant, w_grant_nxt;
`endif

    logic               w_any;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [GNT_W-1:0]   w_gnt_idx;
    logic [MSG_W-1:0]   w_slice;
    logic               w_is_hdr;
    logic [7:0]         w_cur_byte;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_last   (r_rr_last),
        .o_any       (w_any),
        .o_grant_oh  (w_gnt_oh),
        .o_grant_idx (w_gnt_idx)
    );

    // Select the granted requester's payload slice
    always_comb begin
        w_slice = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == GNT_W'(i)) begin
                w_slice = req_data[i*MSG_W +: MSG_W];
            end
        end
    end

`ifdef UART_TX_SCHED_HEADER_EN
    assign w_is_hdr   = (r_idx == '0);
    assign w_cur_byte = w_is_hdr ? {HDR_TAG, r_grant} : r_msg_buf[7:0];
`else
    assign w_is_hdr   = 1'b0;
    assign w_cur_byte = r_msg_buf[7:0];
`endif

    // Next-state logic: arbitrate in IDLE, pulse a byte in SEND, await frame end in WAIT
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = '0;
        w_tx_new_nxt   = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;
        w_msg_buf_nxt  = r_msg_buf;
        w_idx_nxt      = r_idx;
        w_rr_last_nxt  = r_rr_last;
        w_low_seen_nxt = r_low_seen;
`ifdef UART_TX_SCHED_HEADER_EN
        w_grant_nxt    = r_grant;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_msg_buf_nxt = w_slice;
                    w_idx_nxt     = '0;
                    w_rr_last_nxt = w_gnt_idx;
                    w_ack_nxt     = w_gnt_oh;
`ifdef UART_TX_SCHED_HEADER_EN
                    w_grant_nxt   = 4'(w_gnt_idx);
`endif
                    w_state_nxt   = StSend;
                end
            end
            StSend: begin
                if (tx_ready && !r_tx_new_byte) begin
                    w_tx_new_nxt   = 1'b1;
                    w_tx_byte_nxt  = w_cur_byte;
                    w_low_seen_nxt = 1'b0;
                    w_state_nxt    = StWait;
                    if (!w_is_hdr) begin
                        w_msg_buf_nxt = r_msg_buf >> 8;
                    end
                end
            end
            StWait: begin
                if (!tx_ready) begin
                    w_low_seen_nxt = 1'b1;
                end else if (r_low_seen) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = StSend;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_ack         <= '0;
            r_tx_new_byte <= 1'b0;
            r_tx_byte     <= '0;
            r_msg_buf     <= '0;
            r_idx         <= '0;
            r_rr_last     <= GNT_W'(NUM_REQ - 1);
            r_low_seen    <= 1'b0;
`ifdef UART_TX_SCHED_HEADER_EN
            r_grant       <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_ack         <= w_ack_nxt;
            r_tx_new_byte <= w_tx_new_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_msg_buf     <= w_msg_buf_nxt;
            r_idx         <= w_idx_nxt;
            r_rr_last     <= w_rr_last_nxt;
            r_low_seen    <= w_low_seen_nxt;
`ifdef UART_TX_SCHED_HEADER_EN
            r_grant       <= w_grant_nxt;
`endif
        end
    end

    assign req_ack     = r_ack;
    assign tx_new_byte = r_tx_new_byte;
    assign tx_byte     = r_tx_byte;
    assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: behavioural UART transmitter + line decoder,
// and a reference model of round-robin message scheduling.
module tb_uart_tx_scheduler;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned MSG_BYTES    = 4;
    localparam int unsigned CLKS_PER_BIT = 10;
`ifdef UART_TX_SCHED_HEADER_EN
    localparam int unsigned FRAME   = MSG_BYTES + 1;
    localparam bit          HAS_HDR = 1'b1;
`else
    localparam int unsigned FRAME   = MSG_BYTES;
    localparam bit          HAS_HDR = 1'b0;
`endif

    logic                           clk       = 1'b0;
    logic                           reset_n   = 1'b0;
    logic [NUM_REQ-1:0]             req_valid = '0;
    logic [NUM_REQ*MSG_BYTES*8-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]             req_ack;
    logic                           tx_ready;
    logic                           tx_new_byte;
    logic [7:0]                     tx_byte;
    logic                           busy;

    uart_tx_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .MSG_BYTES (MSG_BYTES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_ready    (tx_ready),
        .tx_new_byte (tx_new_byte),
        .tx_byte     (tx_byte),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural 8N1 transmitter (no reset), ready gated low while a new-byte pulse is present
    logic        tx_line  = 1'b1;
    logic        tx_busy  = 1'b0;
    logic [9:0]  tx_frame = '0;
    int unsigned tx_cyc   = 0;
    logic [3:0]  tx_bitpos;
    logic        tx_bit_end;

    assign tx_ready = !tx_busy && (tx_new_byte !== 1'b1);

    always_comb begin
        tx_bitpos  = 4'((tx_cyc + 1) / CLKS_PER_BIT);
        tx_bit_end = ((tx_cyc + 1) % CLKS_PER_BIT) == 0;
    end

    always @(posedge clk) begin
        if (!tx_busy) begin
            if (tx_new_byte === 1'b1) begin
                tx_busy  <= 1'b1;
                tx_frame <= {1'b1, tx_byte, 1'b0};
                tx_line  <= 1'b0;
                tx_cyc   <= 0;
            end
        end else begin
            tx_cyc <= tx_cyc + 1;
            if (tx_bit_end) begin
                if (tx_bitpos == 4'd10) tx_busy <= 1'b0;
                else                    tx_line <= tx_frame[tx_bitpos];
            end
        end
    end

    // Bench state (only the main initial process writes these)
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          g_log[$];
    logic [31:0] m_data[NUM_REQ];
    int          m_rr_last = NUM_REQ - 1;
    bit          keep_valid = 1'b0;
    bit          low_seen = 1'b1;
    logic        prev_ready = 1'b0;
    logic        prev_new = 1'b0;
    int          pulse_cnt = 0;
    int          rx_cnt = 0;
    logic [7:0]  rx_sh = '0;
    int          rx_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Spec rule: first valid requester after the last grant, wrapping
    function automatic int pick(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_rr_last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int glog_at(input int i);
        if (i < g_log.size()) return g_log[i];
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] d);
        req_data[i*32 +: 32] = d;
        m_data[i]            = d;
        req_valid[i]         = 1'b1;
    endtask

    // One cycle: sample at the falling edge, check handshake, model acks, decode the line
    task automatic tick();
        int g;
        int pos;
        @(negedge clk);
        if (tx_new_byte === 1'b1) begin
            check("pulse_after_ready", {31'd0, prev_ready}, 32'd1);
            check("pulse_after_low", {31'd0, low_seen}, 32'd1);
            check("pulse_one_cycle", {31'd0, prev_new}, 32'd0);
            low_seen = 1'b0;
            pulse_cnt++;
        end else if (tx_ready === 1'b0) begin
            low_seen = 1'b1;
        end
        prev_ready = tx_ready;
        prev_new   = tx_new_byte;

        if (req_ack !== '0) begin
            g = pick(req_valid);
            check("ack_grant", 32'(req_ack), (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) begin
                m_rr_last = g;
                g_log.push_back(g);
                if (HAS_HDR) exp_q.push_back({4'hA, 4'(g)});
                for (int b = 0; b < int'(MSG_BYTES); b++) exp_q.push_back(m_data[g][8*b +: 8]);
                if (!keep_valid) req_valid[g] = 1'b0;
            end
        end

        if (rx_cnt == 0) begin
            if (tx_line == 1'b0) rx_cnt = 1;
        end else begin
            rx_cnt++;
            pos = rx_cnt - int'(CLKS_PER_BIT / 2) - 1;
            if (pos > 0 && (pos % int'(CLKS_PER_BIT)) == 0) begin
                pos = pos / int'(CLKS_PER_BIT);
                if (pos <= 8) begin
                    rx_sh[3'(pos - 1)] = tx_line;
                end else begin
                    check("rx_stop_bit", {31'd0, tx_line}, 32'd1);
                    rx_total++;
                    if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_sh), 32'h100);
                    else                   check("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
                    rx_cnt = 0;
                end
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset_n   = 1'b0;
        m_rr_last = NUM_REQ - 1;
        repeat (cycles) tick();
        reset_n = 1'b1;
    endtask

    // Run until no message is pending or in flight (bounded)
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int base;
        int rx0;
        int ones;
        int adds;
        int n;
        int i;
        logic [NUM_REQ-1:0] mask;
        int exp_rr[6];
        exp_rr = '{0, 1, 2, 3, 0, 1};

        // 1: reset with all requests pending
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_ack", 32'(req_ack), 32'd0);
            check("rst_new_byte", {31'd0, tx_new_byte}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        req_valid = '0;
        reset_n   = 1'b1;
        repeat (3) tick();
        check("idle_after_rst", {31'd0, busy}, 32'd0);

        // 2: single message from requester 2
        g_log.delete();
        rx0 = rx_total;
        set_req(2, 32'h44332211);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (g_log.size() == 0 && lat < 20);
        check("t2_ack_latency", lat, 32'd1);
        check("t2_grant", glog_at(0), 32'd2);
        check("t2_valid_dropped", 32'(req_valid), 32'd0);
        tick();
        check("t2_ack_once", 32'(req_ack), 32'd0);
        wait_idle("t2_idle", 4000);
        check("t2_rx_count", rx_total - rx0, FRAME);
        check("t2_bytes_left", exp_q.size(), 32'd0);
        check("t2_one_grant", g_log.size(), 32'd1);

        // 3: fairness with all requesters held valid
        apply_reset(2);
        g_log.delete();
        for (int r = 0; r < int'(NUM_REQ); r++) set_req(r, $urandom);
        keep_valid = 1'b1;
        n = 0;
        while (g_log.size() < 6 && n < 6000) begin
            tick();
            n++;
        end
        keep_valid = 1'b0;
        req_valid  = '0;
        wait_idle("t3_idle", 4000);
        for (int k = 0; k < 6; k++) check("t3_rr_order", glog_at(k), exp_rr[k]);
        check("t3_bytes_left", exp_q.size(), 32'd0);

        // 5: reset after the second byte pulse of a message
        apply_reset(2);
        g_log.delete();
        rx0  = rx_total;
        base = pulse_cnt;
        set_req(2, $urandom);
        n = 0;
        while (pulse_cnt < base + 2 && n < 2000) begin
            tick();
            n++;
        end
        check("t5_two_pulses", pulse_cnt - base, 32'd2);
        for (int k = 0; k < int'(FRAME) - 2; k++) void'(exp_q.pop_back());
        apply_reset(3);
        set_req(0, $urandom);
        set_req(2, $urandom);
        wait_idle("t5_idle", 8000);
        check("t5_first", glog_at(0), 32'd2);
        check("t5_after_rst", glog_at(1), 32'd0);
        check("t5_then", glog_at(2), 32'd2);
        check("t5_pulses", pulse_cnt - base, 2 + 2 * FRAME);
        check("t5_rx_count", rx_total - rx0, 2 + 2 * FRAME);
        check("t5_bytes_left", exp_q.size(), 32'd0);

        // 6: late request arrives while requester 3 is being served
        g_log.delete();
        set_req(3, $urandom);
        n = 0;
        while (g_log.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (30) tick();
        check("t6_busy_mid", {31'd0, busy}, 32'd1);
        set_req(1, $urandom);
        wait_idle("t6_idle", 8000);
        ones = 0;
        foreach (g_log[k]) if (g_log[k] == 1) ones++;
        check("t6_first", glog_at(0), 32'd3);
        check("t6_late", glog_at(1), 32'd1);
        check("t6_ack_once", ones, 32'd1);

        // Randomized rounds with occasional late arrivals
        for (int r = 0; r < 5; r++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int k = 0; k < int'(NUM_REQ); k++) if (mask[k]) set_req(k, $urandom);
            n    = 0;
            adds = 0;
            while ((busy !== 1'b0 || req_valid != '0) && n < 12000) begin
                tick();
                n++;
                if (adds < 3 && $urandom_range(0, 99) == 0) begin
                    i = int'($urandom_range(0, NUM_REQ - 1));
                    if (!req_valid[i]) begin
                        set_req(i, $urandom);
                        adds++;
                    end
                end
            end
            check("rand_idle", {31'd0, busy}, 32'd0);
            check("rand_pending", 32'(req_valid), 32'd0);
        end
        repeat (5) tick();
        check("final_bytes_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
